// File: rtl/drac_pkg.sv
// Shared types for the vector functional unit: operation and element-width
// encodings plus element counts per 64-bit word for each SEW.
package drac_pkg;

  typedef enum logic [3:0] {
    VADD    = 4'd0,
    VSUB    = 4'd1,
    VAND    = 4'd2,
    VOR     = 4'd3,
    VXOR    = 4'd4,
    VMIN    = 4'd5,
    VMINU   = 4'd6,
    VMAX    = 4'd7,
    VMAXU   = 4'd8,
    VMSEQ   = 4'd9,
    VMV     = 4'd10,
    VID     = 4'd11,
    VREDSUM = 4'd12
  } vfu_op_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  localparam int ELEMS_SEW8  = 8;
  localparam int ELEMS_SEW16 = 4;
  localparam int ELEMS_SEW32 = 2;
  localparam int ELEMS_SEW64 = 1;

endpackage

// File: rtl/vfu_lane_alu.sv
// Combinational element-wise ALU for one vector lane. Elements are handled
// zero-extended to 64 bits and the result is trimmed back to SEW.
module vfu_lane_alu
  import drac_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FU_ID_WIDTH = 3
) (
  input  vfu_op_t                op_i,
  input  sew_t                   sew_i,
  input  logic [FU_ID_WIDTH-1:0] fu_id_i,
  input  logic [DATA_WIDTH-1:0]  vs1_i,
  input  logic [DATA_WIDTH-1:0]  vs2_i,
  output logic [DATA_WIDTH-1:0]  vd_o
);

  function automatic logic [63:0] elem_op(input vfu_op_t op, input logic [6:0] w,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] idx);
    logic [63:0] mask, sa, sb, r;
    logic [5:0]  msb;
    mask = (w == 7'd64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = 6'(w - 7'd1);
    // Sign-extend the element so signed compares work at any SEW
    sa   = a[msb] ? (a | ~mask) : a;
    sb   = b[msb] ? (b | ~mask) : b;
    case (op)
      VADD:    r = a + b;
      VSUB:    r = a - b;
      VAND:    r = a & b;
      VOR:     r = a | b;
      VXOR:    r = a ^ b;
      VMIN:    r = ($signed(sa) < $signed(sb)) ? a : b;
      VMINU:   r = (a < b) ? a : b;
      VMAX:    r = ($signed(sa) > $signed(sb)) ? a : b;
      VMAXU:   r = (a > b) ? a : b;
      VMSEQ:   r = (a == b) ? '1 : '0;
      VMV:     r = a;
      VID:     r = idx;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  always_comb begin
    vd_o = '0;
    case (sew_i)
      SEW_8: begin
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW8; i++)
          vd_o[i*8 +: 8] = 8'(elem_op(op_i, 7'd8, 64'(vs1_i[i*8 +: 8]), 64'(vs2_i[i*8 +: 8]),
                                     64'(fu_id_i) * 64'((DATA_WIDTH/64)*ELEMS_SEW8) + 64'(i)));
      end
      SEW_16: begin
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW16; i++)
          vd_o[i*16 +: 16] = 16'(elem_op(op_i, 7'd16, 64'(vs1_i[i*16 +: 16]), 64'(vs2_i[i*16 +: 16]),
                                         64'(fu_id_i) * 64'((DATA_WIDTH/64)*ELEMS_SEW16) + 64'(i)));
      end
      SEW_32: begin
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW32; i++)
          vd_o[i*32 +: 32] = 32'(elem_op(op_i, 7'd32, 64'(vs1_i[i*32 +: 32]), 64'(vs2_i[i*32 +: 32]),
                                         64'(fu_id_i) * 64'((DATA_WIDTH/64)*ELEMS_SEW32) + 64'(i)));
      end
      default: begin
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW64; i++)
          vd_o[i*64 +: 64] = elem_op(op_i, 7'd64, vs1_i[i*64 +: 64], vs2_i[i*64 +: 64],
                                     64'(fu_id_i) * 64'((DATA_WIDTH/64)*ELEMS_SEW64) + 64'(i));
      end
    endcase
  end

endmodule

// File: rtl/vector_functional_unit.sv
// Vector functional unit: lane ALU feeding a STAGES-deep lock-step pipeline.
// Reduction (VREDSUM accumulator) support is built only with VFU_REDUCTION_EN.
module vector_functional_unit
  import drac_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int STAGES      = 2,
  parameter int FU_ID_WIDTH = 3
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  vfu_op_t                op_i,
  input  sew_t                   sew_i,
  input  logic [FU_ID_WIDTH-1:0] fu_id_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic [DATA_WIDTH-1:0]  data_vs1_i,
  input  logic [DATA_WIDTH-1:0]  data_vs2_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  data_vd_o
);

  logic [DATA_WIDTH-1:0]               alu_res;
  logic [DATA_WIDTH-1:0]               stage0_data;
  logic                                bubble;
  logic                                accept;
  logic [STAGES-1:0]                   vld_q, vld_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0]   data_q, data_d;

  vfu_lane_alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FU_ID_WIDTH (FU_ID_WIDTH)
  ) u_alu (
    .op_i    (op_i),
    .sew_i   (sew_i),
    .fu_id_i (fu_id_i),
    .vs1_i   (data_vs1_i),
    .vs2_i   (data_vs2_i),
    .vd_o    (alu_res)
  );

  assign valid_o   = vld_q[STAGES-1];
  assign data_vd_o = data_q[STAGES-1];
  assign ready_o   = !valid_o || ready_i;
  assign accept    = valid_i && ready_o && !flush_i;

`ifdef VFU_REDUCTION_EN
  logic [63:0] acc_q, acc_d, red_sum, red_mask, red_base, red_acc;
  logic        red_open_q, red_open_d, is_red;

  assign is_red = (op_i == VREDSUM);

  always_comb begin
    red_sum  = '0;
    red_mask = '1;
    case (sew_i)
      SEW_8: begin
        red_mask = 64'hFF;
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW8; i++) red_sum += 64'(data_vs2_i[i*8 +: 8]);
      end
      SEW_16: begin
        red_mask = 64'hFFFF;
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW16; i++) red_sum += 64'(data_vs2_i[i*16 +: 16]);
      end
      SEW_32: begin
        red_mask = 64'hFFFF_FFFF;
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW32; i++) red_sum += 64'(data_vs2_i[i*32 +: 32]);
      end
      default: begin
        for (int i = 0; i < (DATA_WIDTH/64)*ELEMS_SEW64; i++) red_sum += data_vs2_i[i*64 +: 64];
      end
    endcase
    // A beat that finds no open reduction seeds from vs1 element 0
    red_base = (first_i || !red_open_q) ? (data_vs1_i[63:0] & red_mask) : acc_q;
    red_acc  = (red_base + red_sum) & red_mask;
  end

  always_comb begin
    acc_d      = acc_q;
    red_open_d = red_open_q;
    if (flush_i) begin
      acc_d      = '0;
      red_open_d = 1'b0;
    end else if (accept && is_red) begin
      acc_d      = last_i ? '0 : red_acc;
      red_open_d = !last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q      <= '0;
      red_open_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      red_open_q <= red_open_d;
    end
  end

  assign stage0_data = is_red ? DATA_WIDTH'(red_acc) : alu_res;
  assign bubble      = is_red && !last_i;
`else
  logic unused_red_flags;
  assign unused_red_flags = first_i ^ last_i;
  assign stage0_data      = alu_res;
  assign bubble           = 1'b0;
`endif

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = '0;
    end else if (ready_o) begin
      vld_d[0]  = accept && !bubble;
      data_d[0] = accept ? stage0_data : data_q[0];
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        data_d[s] = data_q[s-1];
      end
    end
  end

  // ---- pipeline registers (stage 0 .. STAGES-1) ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: doc/vector_functional_unit.md
VECTOR_FUNCTIONAL_UNIT -- requirements
Module: vector_functional_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set lane data width (multiple of 64).
REQ-002 Parameter STAGES, default 2, SHALL set pipeline depth (1..4).
REQ-003 Parameter FU_ID_WIDTH, default 3, SHALL set width of fu_id_i.
REQ-004 clk_i  in  1  SHALL be the single clock, rising edge.
REQ-005 rstn_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 flush_i  in  1  SHALL kill all in-flight ops and any partial reduction.
REQ-007 valid_i / ready_o  in/out  1/1  SHALL be the input handshake.
REQ-008 op_i  in  vfu_op_t  SHALL select the operation.
REQ-009 sew_i  in  sew_t  SHALL select element width: 8/16/32/64.
REQ-010 fu_id_i  in  FU_ID_WIDTH  SHALL give this unit's lane index.
REQ-011 first_i, last_i  in  1 each  SHALL mark the first and last beats of a reduction.
REQ-012 data_vs1_i, data_vs2_i  in  DATA_WIDTH each  SHALL be the source operands.
REQ-013 valid_o / ready_i  out/in  1/1  SHALL be the output handshake.
REQ-014 data_vd_o  out  DATA_WIDTH  SHALL be the result.

Function
REQ-015 Ops SHALL be: VADD, VSUB, VAND, VOR, VXOR, VMIN, VMINU, VMAX, VMAXU, VMSEQ, VMV, VID, VREDSUM.
- Element-wise, per sew_i.
- Arithmetic wraps modulo SEW.
- VMSEQ writes all-ones/zero per element.
- Undefined op yields 0.
REQ-016 VID element i SHALL be fu_id_i*(DATA_WIDTH/SEW)+i, truncated to SEW.
REQ-017 Input acceptance SHALL occur when valid_i && ready_o.
- The result is computed combinationally into stage 0.
- It propagates one stage per cycle.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to valid_o with ready_i held high.
- Throughput is one op per cycle.
REQ-019 The pipeline SHALL advance as a whole.
- ready_o = !valid_o || ready_i.
- When stalled, every stage and data_vd_o hold their values.
- Bubbles are not collapsed.
REQ-020 valid_o SHALL remain high, and data_vd_o stable, until ready_i is sampled high.
REQ-021 VREDSUM (when REQ-033 is enabled) SHALL sum all SEW elements of data_vs2_i into an accumulator.
- First beat: accumulator = element0(vs1) + sum(vs2).
- Later beats: accumulator += sum(vs2).
- Wraps modulo SEW.
REQ-022 A VREDSUM beat with last_i=0 SHALL enter the pipeline as a bubble and produce no valid_o.
REQ-023 A VREDSUM beat with last_i=1 SHALL emit the final accumulator, zero-extended, in element 0.
- It follows REQ-018 latency.
REQ-024 A beat with first_i=1 && last_i=1 SHALL be a complete single-beat reduction.
REQ-025 A first_i=1 beat arriving during an open reduction SHALL discard the old accumulator and restart.
REQ-026 Non-reduction ops accepted during an open reduction SHALL execute normally and leave the accumulator unchanged.
REQ-027 On flush_i:
- All stage valids clear and the accumulator state closes by the next edge.
- A valid_i coincident with flush_i is dropped.
- ready_o is 1 in the following cycle.
REQ-028 sew_i SHALL be sampled per beat; mixed SEW within one reduction is undefined.

Reset
REQ-029 While rstn_i=0:
- valid_o=0, data_vd_o=0, ready_o=1.
- All stage valids and data are 0.
- Accumulator=0; reduction-open flag=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight ops and partial reductions, asynchronously.
REQ-031 After rstn_i deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-032 The macro VFU_REDUCTION_EN SHALL gate reduction support.
REQ-033 With VFU_REDUCTION_EN defined:
- The accumulator and REQ-021..REQ-025 are present.
REQ-034 Without VFU_REDUCTION_EN:
- No accumulator is instantiated.
- VREDSUM is treated as an undefined op: result 0, one valid_o per accepted beat.
- first_i and last_i are ignored.

Structure
REQ-035 vfu_op_t, sew_t and the per-SEW element-count constants SHALL live in drac_pkg.
REQ-036 Element-wise ops SHALL sit in one combinational sub-module, vfu_lane_alu.
- Pipeline, handshake and accumulator SHALL sit in vector_functional_unit.

Verification
REQ-037 Each listed scenario SHALL be covered by a directed test:
- VADD SEW_8, vs1=0x01..01, vs2=0xFF..FF, STAGES=2, ready_i=1 -> valid_o 2 cycles later, data_vd_o=0.
- VID SEW_16, fu_id_i=3, DATA_WIDTH=64 -> data_vd_o=0x000F_000E_000D_000C.
- VREDSUM SEW_32, three beats, vs2={1,2},{3,4},{5,6}, vs1 elem0=10 -> single valid_o with data_vd_o=31; no output for beats 1-2.
- Backpressure: ready_i=0 for 3 cycles with a full pipeline -> ready_o=0, data_vd_o stable; ready_i=1 drains in order with no loss or duplication.
- flush_i mid-reduction after beat 2, then a first+last VREDSUM with vs2=0, vs1=7 -> output 7, no stale sum.
- rstn_i pulsed low with 2 ops in flight -> valid_o=0 immediately; no outputs after release.
